// File: rtl/key_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_sweep_ctrl
// Description : Brute-force key sweep controller. Steps a 24-bit key from
//               KEY_LO towards KEY_HI in KEY_STEP increments, restarts the
//               decryption sequencer for every key and stops on the first
//               key the plaintext checker accepts or when the range runs out.
//               Optional WAIT_DONE watchdog: define KEY_SWEEP_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module key_sweep_ctrl #(
    parameter logic [23:0] KEY_LO         = 24'h000000,
    parameter logic [23:0] KEY_HI         = 24'h3FFFFF,
    parameter logic [23:0] KEY_STEP       = 24'd1,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        seq_done,
    input  logic        msg_valid,
    output logic [23:0] secret_key,
    output logic        seq_restart,
    output logic        new_key_available,
    output logic        found,
    output logic        exhausted,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESTART   = 3'd1,
        ST_KEY_READY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CHECK     = 3'd4,
        ST_ADVANCE   = 3'd5,
        ST_FOUND     = 3'd6,
        ST_EXHAUSTED = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_key;
    logic        w_start_ok;
    logic [24:0] w_key_sum;
    logic        w_past_end;
    logic        w_hit;
    logic        w_wd_fire;

    // A new sweep may only be launched from a resting state.
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_FOUND) ||
                                  (r_state == ST_EXHAUSTED));

    // Widened to 25 bits so a step past 24'hFFFFFF cannot wrap back into range.
    assign w_key_sum  = {1'b0, r_key} + {1'b0, KEY_STEP};
    assign w_past_end = (w_key_sum > {1'b0, KEY_HI});

`ifdef KEY_SWEEP_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wd_cnt;
    logic        r_timeout;
    logic        r_key_timed_out;

    // Watchdog fires on the last allowed WAIT_DONE cycle; a real done wins a tie.
    assign w_wd_fire = (r_state == ST_WAIT_DONE) && !seq_done && (r_wd_cnt == WD_LAST);

    // A key abandoned by the watchdog must not be declared a hit.
    assign w_hit     = msg_valid && !r_key_timed_out;
    assign timeout   = r_timeout;

    // Watchdog counter runs only in WAIT_DONE and restarts from 0 on each entry.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= 16'd0;
        end else if (r_state != ST_WAIT_DONE) begin
            r_wd_cnt <= 16'd0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end

    // Sticky sweep-level timeout flag plus a per-key marker for the CHECK stage.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_timeout       <= 1'b0;
            r_key_timed_out <= 1'b0;
        end else begin
            if (abort || w_start_ok) begin
                r_timeout <= 1'b0;
            end else if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end
            if (w_wd_fire) begin
                r_key_timed_out <= 1'b1;
            end else if (r_state == ST_RESTART) begin
                r_key_timed_out <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_wd_fire          = 1'b0;
    assign w_hit              = msg_valid;
    assign timeout            = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    if (start) begin
                        w_next = ST_RESTART;
                    end
                end
                ST_RESTART:   w_next = ST_KEY_READY;
                ST_KEY_READY: w_next = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (seq_done || w_wd_fire) begin
                        w_next = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_hit) begin
                        w_next = ST_FOUND;
                    end else if (w_past_end) begin
                        w_next = ST_EXHAUSTED;
                    end else begin
                        w_next = ST_ADVANCE;
                    end
                end
                ST_ADVANCE:   w_next = ST_RESTART;
                default:      w_next = ST_IDLE;
            endcase
        end
    end

    // Key under test: reloaded on start/abort, stepped only in ADVANCE.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_key <= KEY_LO;
        end else if (abort || w_start_ok) begin
            r_key <= KEY_LO;
        end else if (r_state == ST_ADVANCE) begin
            r_key <= w_key_sum[23:0];
        end
    end

    // Sequencer is held in reset while idle and pulsed once per key.
    assign secret_key        = r_key;
    assign seq_restart       = (r_state == ST_IDLE) || (r_state == ST_RESTART);
    assign new_key_available = (r_state == ST_KEY_READY);
    assign found             = (r_state == ST_FOUND);
    assign exhausted         = (r_state == ST_EXHAUSTED);
    assign busy              = (r_state == ST_RESTART)   || (r_state == ST_KEY_READY) ||
                               (r_state == ST_WAIT_DONE) || (r_state == ST_CHECK)     ||
                               (r_state == ST_ADVANCE);

endmodule
`default_nettype wire

// File: tb/tb_key_sweep_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_key_sweep_ctrl
// Description : Directed bench for key_sweep_ctrl. Instance A sweeps 0..3 step
//               1, instance B sweeps 1..5 step 2. Each instance has a small
//               sequencer responder raising seq_done 3 cycles after the key
//               is released.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_start = 1'b0, a_abort = 1'b0, a_seq_done = 1'b0, a_msg_valid = 1'b0;
    logic [23:0] a_key;
    logic        a_restart, a_nka, a_found, a_exh, a_busy, a_to;

    logic        b_start = 1'b0, b_abort = 1'b0, b_seq_done = 1'b0, b_msg_valid = 1'b0;
    logic [23:0] b_key;
    logic        b_restart, b_nka, b_found, b_exh, b_busy, b_to;

    logic        a_rsp_en = 1'b0, a_win_en = 1'b0;
    logic [23:0] a_win_key = 24'd0;
    logic        b_rsp_en = 1'b0;
    int          a_wait = 0, b_wait = 0;
    int          a_cyc = 0;
    int          a_rst_cnt = 0;
    logic [23:0] a_keys[$];
    int          a_nka_cyc[$];
    logic [23:0] b_keys[$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_sweep_ctrl #(
        .KEY_LO(24'd0), .KEY_HI(24'd3), .KEY_STEP(24'd1), .TIMEOUT_CYCLES(10)
    ) dut_a (
        .CLOCK_50(clk), .reset(rst), .start(a_start), .abort(a_abort),
        .seq_done(a_seq_done), .msg_valid(a_msg_valid), .secret_key(a_key),
        .seq_restart(a_restart), .new_key_available(a_nka), .found(a_found),
        .exhausted(a_exh), .busy(a_busy), .timeout(a_to)
    );

    key_sweep_ctrl #(
        .KEY_LO(24'd1), .KEY_HI(24'd5), .KEY_STEP(24'd2), .TIMEOUT_CYCLES(10)
    ) dut_b (
        .CLOCK_50(clk), .reset(rst), .start(b_start), .abort(b_abort),
        .seq_done(b_seq_done), .msg_valid(b_msg_valid), .secret_key(b_key),
        .seq_restart(b_restart), .new_key_available(b_nka), .found(b_found),
        .exhausted(b_exh), .busy(b_busy), .timeout(b_to)
    );

    // Monitor and sequencer responder for instance A.
    always @(negedge clk) begin
        a_cyc++;
        if (a_busy && a_restart) a_rst_cnt++;
        if (a_nka) begin
            a_keys.push_back(a_key);
            a_nka_cyc.push_back(a_cyc);
        end
        if (!a_rsp_en) begin
            a_seq_done = 1'b0; a_msg_valid = 1'b0; a_wait = 0;
        end else if (a_restart) begin
            a_seq_done = 1'b0; a_msg_valid = 1'b0; a_wait = 0;
        end else if (a_nka) begin
            a_wait = 1;
        end else if (a_wait == 3) begin
            a_seq_done  = 1'b1;
            a_msg_valid = a_win_en && (a_key == a_win_key);
            a_wait      = 0;
        end else if (a_wait != 0) begin
            a_wait++;
        end
    end

    // Monitor and sequencer responder for instance B (never accepts a key).
    always @(negedge clk) begin
        if (b_nka) b_keys.push_back(b_key);
        if (!b_rsp_en || b_restart) begin
            b_seq_done = 1'b0; b_msg_valid = 1'b0; b_wait = 0;
        end else if (b_nka) begin
            b_wait = 1;
        end else if (b_wait == 3) begin
            b_seq_done = 1'b1; b_wait = 0;
        end else if (b_wait != 0) begin
            b_wait++;
        end
    end

    task automatic a_pulse_start();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    task automatic a_wait_idle(input int max_cyc);
        int n = 0;
        while (a_busy && n < max_cyc) begin @(negedge clk); n++; end
        checks++;
        if (a_busy !== 1'b0) begin
            failures++;
            $display("FAIL a_sweep_end_timeout busy=%0b expected 0 after %0d cycles", a_busy, max_cyc);
        end
    endtask

    task automatic a_wait_nka(input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (!a_nka && n < max_cyc) begin @(negedge clk); n++; end
        checks++;
        if (a_nka !== 1'b1) begin
            failures++;
            $display("FAIL a_nka_wait new_key_available=%0b expected 1", a_nka);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_key, a_restart, a_nka, a_found, a_exh, a_busy, a_to} !== {24'd0, 6'b100000}) begin
            failures++;
            $display("FAIL reset_outputs_a got key=%0h rs=%0b nka=%0b f=%0b e=%0b b=%0b t=%0b expected key=0 rs=1 rest 0",
                     a_key, a_restart, a_nka, a_found, a_exh, a_busy, a_to);
        end
        checks++;
        if (b_key !== 24'd1) begin
            failures++; $display("FAIL reset_key_b got %0h expected 1", b_key);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_found();
        int kb = a_keys.size();
        int rb = a_rst_cnt;
        a_rsp_en = 1'b1; a_win_en = 1'b1; a_win_key = 24'd2;
        a_pulse_start();
        a_wait_idle(200);
        checks++;
        if (a_found !== 1'b1 || a_exh !== 1'b0) begin
            failures++; $display("FAIL found_flags got f=%0b e=%0b expected f=1 e=0", a_found, a_exh);
        end
        checks++;
        if (a_key !== 24'd2) begin
            failures++; $display("FAIL found_key got %0h expected 2", a_key);
        end
        checks++;
        if (a_rst_cnt - rb != 3) begin
            failures++; $display("FAIL found_restart_pulses got %0d expected 3", a_rst_cnt - rb);
        end
        checks++;
        if (a_keys.size() - kb != 3) begin
            failures++; $display("FAIL found_nka_pulses got %0d expected 3", a_keys.size() - kb);
        end
        checks++;
        if (a_nka_cyc.size() < kb + 2) begin
            failures++; $display("FAIL key_latency got too few pulses %0d expected gap 7", a_nka_cyc.size() - kb);
        end else if (a_nka_cyc[kb+1] - a_nka_cyc[kb] != 7) begin
            failures++; $display("FAIL key_latency got gap %0d expected 7", a_nka_cyc[kb+1] - a_nka_cyc[kb]);
        end
        checks++;
        if (a_restart !== 1'b0) begin
            failures++; $display("FAIL found_restart_low got %0b expected 0", a_restart);
        end
    endtask

    task automatic test_exhausted();
        int kb = a_keys.size();
        a_rsp_en = 1'b1; a_win_en = 1'b0;
        a_pulse_start();
        a_wait_idle(200);
        checks++;
        if (a_exh !== 1'b1 || a_found !== 1'b0) begin
            failures++; $display("FAIL exh_flags got e=%0b f=%0b expected e=1 f=0", a_exh, a_found);
        end
        checks++;
        if (a_key !== 24'd3) begin
            failures++; $display("FAIL exh_key got %0h expected 3", a_key);
        end
        checks++;
        if (a_keys.size() - kb != 4) begin
            failures++; $display("FAIL exh_nka_pulses got %0d expected 4", a_keys.size() - kb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (a_keys[kb+i] !== 24'(i)) begin
                    failures++; $display("FAIL exh_key_order[%0d] got %0h expected %0h", i, a_keys[kb+i], i);
                end
            end
        end
    endtask

    task automatic test_step();
        int kb = b_keys.size();
        int n = 0;
        logic [23:0] exp_k [3] = '{24'd1, 24'd3, 24'd5};
        b_rsp_en = 1'b1;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        while (b_busy && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (b_exh !== 1'b1 || b_key !== 24'd5) begin
            failures++; $display("FAIL step_end got e=%0b key=%0h expected e=1 key=5", b_exh, b_key);
        end
        checks++;
        if (b_keys.size() - kb != 3) begin
            failures++; $display("FAIL step_key_count got %0d expected 3", b_keys.size() - kb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (b_keys[kb+i] !== exp_k[i]) begin
                    failures++; $display("FAIL step_key[%0d] got %0h expected %0h", i, b_keys[kb+i], exp_k[i]);
                end
            end
        end
        b_rsp_en = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int kb = a_keys.size();
        a_rsp_en = 1'b1; a_win_en = 1'b0;
        @(negedge clk); a_start = 1'b1;
        repeat (10) @(negedge clk);
        a_start = 1'b0;
        a_wait_idle(200);
        checks++;
        if (a_keys.size() - kb != 4 || a_exh !== 1'b1) begin
            failures++; $display("FAIL start_busy_ignored got pulses=%0d e=%0b expected 4 e=1", a_keys.size() - kb, a_exh);
        end
    endtask

    task automatic test_abort_start();
        a_rsp_en = 1'b0;
        a_pulse_start();
        a_wait_nka(20);
        repeat (2) @(negedge clk);
        checks++;
        if (a_busy !== 1'b1) begin
            failures++; $display("FAIL abort_pre_busy got %0b expected 1", a_busy);
        end
        a_abort = 1'b1; a_start = 1'b1;
        @(negedge clk);
        a_abort = 1'b0; a_start = 1'b0;
        checks++;
        if ({a_busy, a_found, a_exh, a_restart, a_to} !== 5'b00010 || a_key !== 24'd0) begin
            failures++; $display("FAIL abort_state got b=%0b f=%0b e=%0b rs=%0b t=%0b key=%0h expected b=0 f=0 e=0 rs=1 t=0 key=0",
                                 a_busy, a_found, a_exh, a_restart, a_to, a_key);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin
            failures++; $display("FAIL abort_stays_idle got busy=%0b expected 0", a_busy);
        end
    endtask

    task automatic test_timeout();
`ifdef KEY_SWEEP_TIMEOUT_EN
        a_rsp_en = 1'b0;
        a_pulse_start();
        a_wait_nka(20);
        repeat (10) @(negedge clk);
        checks++;
        if (a_to !== 1'b0 || a_busy !== 1'b1) begin
            failures++; $display("FAIL timeout_early got t=%0b b=%0b expected t=0 b=1", a_to, a_busy);
        end
        @(negedge clk);
        checks++;
        if (a_to !== 1'b1) begin
            failures++; $display("FAIL timeout_set got %0b expected 1", a_to);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (a_nka !== 1'b1 || a_key !== 24'd1 || a_to !== 1'b1) begin
            failures++; $display("FAIL timeout_advance got nka=%0b key=%0h t=%0b expected nka=1 key=1 t=1", a_nka, a_key, a_to);
        end
`else
        int kb = a_keys.size();
        a_rsp_en = 1'b0;
        a_pulse_start();
        repeat (40) @(negedge clk);
        checks++;
        if (a_to !== 1'b0 || a_busy !== 1'b1 || a_keys.size() - kb != 1) begin
            failures++; $display("FAIL no_timeout_wait got t=%0b b=%0b pulses=%0d expected t=0 b=1 pulses=1",
                                 a_to, a_busy, a_keys.size() - kb);
        end
`endif
        @(negedge clk); a_abort = 1'b1;
        @(negedge clk); a_abort = 1'b0;
        checks++;
        if (a_to !== 1'b0 || a_busy !== 1'b0) begin
            failures++; $display("FAIL timeout_abort_clear got t=%0b b=%0b expected 0 0", a_to, a_busy);
        end
    endtask

    task automatic test_reset_midway();
        int n = 0;
        int kb;
        a_rsp_en = 1'b1; a_win_en = 1'b1; a_win_key = 24'd3;
        a_pulse_start();
        while (!(a_nka && a_key == 24'd1) && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (a_nka !== 1'b1 || a_key !== 24'd1) begin
            failures++; $display("FAIL midway_reach got nka=%0b key=%0h expected nka=1 key=1", a_nka, a_key);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_busy, a_nka, a_restart, a_found, a_exh} !== 5'b00100 || a_key !== 24'd0) begin
            failures++; $display("FAIL async_reset got b=%0b nka=%0b rs=%0b f=%0b e=%0b key=%0h expected 0 0 1 0 0 key=0",
                                 a_busy, a_nka, a_restart, a_found, a_exh, a_key);
        end
        @(negedge clk); rst = 1'b0;
        kb = a_keys.size();
        a_pulse_start();
        a_wait_idle(200);
        checks++;
        if (a_keys.size() <= kb) begin
            failures++; $display("FAIL post_reset_first_key got no pulse expected key 0");
        end else if (a_keys[kb] !== 24'd0) begin
            failures++; $display("FAIL post_reset_first_key got %0h expected 0", a_keys[kb]);
        end
        checks++;
        if (a_found !== 1'b1 || a_key !== 24'd3) begin
            failures++; $display("FAIL post_reset_found got f=%0b key=%0h expected f=1 key=3", a_found, a_key);
        end
    endtask

    initial begin
        test_reset();
        test_found();
        test_exhausted();
        test_step();
        test_start_while_busy();
        test_abort_start();
        test_timeout();
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
